// File: rtl/program_sequencer_if.sv
// Issue handshake between the program sequencer (initiator) and the bus processor.
// The sequencer drives the instruction/data word and the run pulse; the processor answers with done.
interface program_sequencer_if #(
    parameter int REG_WIDTH = 16
);
    logic [REG_WIDTH-1:0] din;
    logic                 run;
    logic                 done;

    modport master (output din, output run, input done);
    modport slave  (input din, input run, output done);
endinterface

// File: rtl/program_sequencer.sv
// Feeds a stored program to the multi-cycle bus processor, one instruction per run/done exchange.
// The immediate word of an mvi is presented during the WAIT that follows its opcode.
module program_sequencer #(
    parameter int REG_WIDTH         = 16,
    parameter int INSTRUCTION_WIDTH = 9,
    parameter int ADDR_WIDTH        = 6,
    parameter int TIMEOUT           = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [REG_WIDTH-1:0]  wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len,
    program_sequencer_if.master   bus,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   pc,
    output logic [15:0]           retired
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FIN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [REG_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH:0]  pc_r;
    logic [ADDR_WIDTH:0]  len_r;
    logic [15:0]          retired_r;
    logic [CNT_W-1:0]     cnt_r;

    logic [ADDR_WIDTH:0]  pc_inc1_s;
    logic [ADDR_WIDTH:0]  pc_next_s;
    logic [REG_WIDTH-1:0] cur_word_s;
    logic [REG_WIDTH-1:0] imm_word_s;
    logic                 is_mvi_s;
    logic                 trunc_s;
    logic                 timeout_s;
    logic                 run_s;
    logic [REG_WIDTH-1:0] din_s;
    logic                 busy_s;
    logic                 finished_s;
    logic                 error_s;

    assign pc_inc1_s  = pc_r + (ADDR_WIDTH+1)'(1);
    assign cur_word_s = mem_r[pc_r[ADDR_WIDTH-1:0]];
    assign imm_word_s = mem_r[pc_inc1_s[ADDR_WIDTH-1:0]];
    assign is_mvi_s   = (cur_word_s[INSTRUCTION_WIDTH-1 -: 3] == 3'b001);
    // An mvi whose immediate would lie past the program end is never issued.
    assign trunc_s    = is_mvi_s && (pc_inc1_s >= len_r);
    assign pc_next_s  = is_mvi_s ? (pc_r + (ADDR_WIDTH+1)'(2)) : pc_inc1_s;
    assign timeout_s  = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Program memory: host writes only while no program is running.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_FIN, S_ERR: begin
                if (start) begin
                    state_next_s = (len == (ADDR_WIDTH+1)'(0)) ? S_FIN : S_ISSUE;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_ISSUE: begin
                if (bus.done || trunc_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.done) begin
                    state_next_s = (pc_next_s >= len_r) ? S_FIN : S_ISSUE;
                end else if (timeout_s) begin
                    state_next_s = S_ERR;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Program counter, retire count, latched length and WAIT timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= (ADDR_WIDTH+1)'(0);
            len_r     <= (ADDR_WIDTH+1)'(0);
            retired_r <= 16'd0;
            cnt_r     <= CNT_W'(0);
        end else begin
            case (state_r)
                S_IDLE, S_FIN, S_ERR: begin
                    if (start) begin
                        pc_r      <= (ADDR_WIDTH+1)'(0);
                        len_r     <= len;
                        retired_r <= 16'd0;
                        cnt_r     <= CNT_W'(0);
                    end
                end
                S_ISSUE: cnt_r <= CNT_W'(0);
                S_WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (bus.done) begin
                        pc_r <= pc_next_s;
                        if (retired_r != 16'hFFFF) begin
                            retired_r <= retired_r + 16'd1;
                        end
                    end
                end
                default: cnt_r <= CNT_W'(0);
            endcase
        end
    end

    // Moore output decode.
    always_comb begin
        run_s      = 1'b0;
        din_s      = '0;
        busy_s     = 1'b0;
        finished_s = 1'b0;
        error_s    = 1'b0;
        case (state_r)
            S_ISSUE: begin
                busy_s = 1'b1;
                if (!trunc_s) begin
                    run_s = 1'b1;
                    din_s = cur_word_s;
                end else begin
                    run_s = 1'b0;
                    din_s = '0;
                end
            end
            S_WAIT: begin
                busy_s = 1'b1;
                if (is_mvi_s) begin
                    din_s = imm_word_s;
                end else begin
                    din_s = '0;
                end
            end
            S_FIN:   finished_s = 1'b1;
            S_ERR:   error_s    = 1'b1;
            default: busy_s     = 1'b0;
        endcase
    end

    assign bus.run  = run_s;
    assign bus.din  = din_s;
    assign busy     = busy_s;
    assign finished = finished_s;
    assign error    = error_s;
    assign pc       = pc_r;
    assign retired  = retired_r;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a small behavioural model of the bus processor.
module tb_program_sequencer;
    localparam int RW = 16;
    localparam int AW = 6;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic          start;
    logic [AW:0]   len;
    logic          busy, finished, error;
    logic [AW:0]   pc;
    logic [15:0]   retired;

    program_sequencer_if #(.REG_WIDTH(RW)) bus ();

    program_sequencer #(.REG_WIDTH(RW), .INSTRUCTION_WIDTH(9), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .bus(bus), .busy(busy), .finished(finished),
        .error(error), .pc(pc), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;   // 0: processor model, 1: never done, 2: done during ISSUE
    logic [15:0] prog [5] = '{16'h0040, 16'h0005, 16'h0048, 16'h0003, 16'h0081};

    // Processor model: IR loads on run, executes in T1, pulses done in T2.
    logic [15:0] r [8];
    logic [15:0] ir;
    logic        step;
    logic        proc_done;
    always @(posedge clk) begin
        if (rst) begin
            step <= 1'b0;
            proc_done <= 1'b0;
            ir <= 16'h0000;
            for (int i = 0; i < 8; i++) r[i] <= 16'h0000;
        end else begin
            proc_done <= 1'b0;
            if (bus.run) begin
                ir   <= bus.din;
                step <= 1'b1;
            end else if (step) begin
                step <= 1'b0;
                case (ir[8:6])
                    3'b000:  r[ir[5:3]] <= r[ir[2:0]];
                    3'b001:  r[ir[5:3]] <= bus.din;
                    3'b010:  r[ir[5:3]] <= r[ir[5:3]] + r[ir[2:0]];
                    3'b011:  r[ir[5:3]] <= r[ir[5:3]] - r[ir[2:0]];
                    default: r[0] <= r[0];
                endcase
                if (mode == 0) proc_done <= 1'b1;
            end
        end
    end
    assign bus.done = (mode == 2) ? bus.run : proc_done;

    // Bus monitor: counts run pulses and captures din in the cycle after each run.
    int          run_cnt = 0;
    int          overlap = 0;
    logic        prev_run = 1'b0;
    logic [15:0] imm_q [$];
    always @(negedge clk) begin
        if (prev_run) imm_q.push_back(bus.din);
        if (prev_run && bus.run) overlap <= overlap + 1;
        if (bus.run) run_cnt <= run_cnt + 1;
        prev_run <= bus.run;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic launch(input logic [AW:0] l);
        len = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 200; i++) begin
            if (finished || error) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; len = '0; wr_addr = '0; wr_data = '0; mode = 0;
        tick(); tick();
        n_cmp++; if ({bus.run, busy, finished, error} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {bus.run, busy, finished, error}); end
        n_cmp++; if (bus.din !== 16'h0000) begin n_bad++; $display("FAIL reset_din: got %h expected 0000", bus.din); end
        n_cmp++; if (pc !== 7'd0) begin n_bad++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        n_cmp++; if (retired !== 16'd0) begin n_bad++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_program();
        int base;
        for (int i = 0; i < 5; i++) write_word(AW'(i), prog[i]);
        imm_q.delete();
        base = run_cnt;
        launch(7'd5);
        wait_end();
        n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL prog_finished: got %b expected 1", finished); end
        n_cmp++; if (pc !== 7'd5) begin n_bad++; $display("FAIL prog_pc: got %0d expected 5", pc); end
        n_cmp++; if (retired !== 16'd3) begin n_bad++; $display("FAIL prog_retired: got %0d expected 3", retired); end
        n_cmp++; if (r[0] !== 16'h0008) begin n_bad++; $display("FAIL prog_r0: got %h expected 0008", r[0]); end
        n_cmp++; if (run_cnt - base !== 3) begin n_bad++; $display("FAIL prog_runs: got %0d expected 3", run_cnt - base); end
        n_cmp++; if (imm_q.size() !== 3) begin n_bad++; $display("FAIL prog_wait_count: got %0d expected 3", imm_q.size()); end
        n_cmp++; if (imm_q[0] !== 16'h0005) begin n_bad++; $display("FAIL prog_imm0: got %h expected 0005", imm_q[0]); end
        n_cmp++; if (imm_q[1] !== 16'h0003) begin n_bad++; $display("FAIL prog_imm1: got %h expected 0003", imm_q[1]); end
        n_cmp++; if (imm_q[2] !== 16'h0000) begin n_bad++; $display("FAIL prog_add_wait_din: got %h expected 0000", imm_q[2]); end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL prog_run_back_to_back: got %0d expected 0", overlap); end
    endtask

    task automatic test_zero_len();
        int base;
        base = run_cnt;
        launch(7'd0);
        n_cmp++; if (finished !== 1'b1) begin n_bad++; $display("FAIL zero_finished: got %b expected 1", finished); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b expected 0", busy); end
        n_cmp++; if (retired !== 16'd0) begin n_bad++; $display("FAIL zero_retired: got %0d expected 0", retired); end
        tick();
        n_cmp++; if (run_cnt !== base) begin n_bad++; $display("FAIL zero_runs: got %0d expected %0d", run_cnt, base); end
    endtask

    task automatic test_truncated();
        int base;
        write_word(AW'(0), 16'h0040);
        base = run_cnt;
        launch(7'd1);
        n_cmp++; if (bus.run !== 1'b0) begin n_bad++; $display("FAIL trunc_run: got %b expected 0", bus.run); end
        n_cmp++; if (bus.din !== 16'h0000) begin n_bad++; $display("FAIL trunc_din: got %h expected 0000", bus.din); end
        tick();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL trunc_error: got %b expected 1", error); end
        n_cmp++; if (pc !== 7'd0) begin n_bad++; $display("FAIL trunc_pc: got %0d expected 0", pc); end
        n_cmp++; if (run_cnt !== base) begin n_bad++; $display("FAIL trunc_runs: got %0d expected %0d", run_cnt, base); end
    endtask

    task automatic test_timeout();
        int n;
        mode = 1;
        write_word(AW'(0), 16'h0081);
        launch(7'd1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (error) begin n = i; break; end
        end
        n_cmp++; if (n !== TO + 1) begin n_bad++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TO + 1); end
        n_cmp++; if (retired !== 16'd0) begin n_bad++; $display("FAIL timeout_retired: got %0d expected 0", retired); end
        mode = 0;
    endtask

    task automatic test_protocol();
        mode = 2;
        launch(7'd1);
        n_cmp++; if (bus.run !== 1'b1) begin n_bad++; $display("FAIL proto_issue_run: got %b expected 1", bus.run); end
        tick();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL proto_error: got %b expected 1", error); end
        n_cmp++; if (retired !== 16'd0) begin n_bad++; $display("FAIL proto_retired: got %0d expected 0", retired); end
        mode = 0;
        tick();
    endtask

    task automatic test_reset_mid_and_lockout();
        int base;
        for (int i = 0; i < 5; i++) write_word(AW'(i), prog[i]);
        launch(7'd5);
        for (int i = 0; i < 20; i++) begin
            if (pc == 7'd2 && busy && !bus.run) break;
            tick();
        end
        n_cmp++; if (!(pc == 7'd2 && busy && !bus.run)) begin n_bad++; $display("FAIL mid_reach_wait2: got pc=%0d busy=%b expected pc=2 busy=1", pc, busy); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({bus.run, busy, finished, error} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_flags: got %b expected 0000", {bus.run, busy, finished, error}); end
        n_cmp++; if (bus.din !== 16'h0000) begin n_bad++; $display("FAIL mid_rst_din: got %h expected 0000", bus.din); end
        n_cmp++; if ({pc, retired} !== 23'd0) begin n_bad++; $display("FAIL mid_rst_pc_retired: got %0d/%0d expected 0/0", pc, retired); end
        rst = 1'b0;
        base = run_cnt;
        tick(); tick(); tick();
        n_cmp++; if (run_cnt !== base || busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle_after_rst: got runs=%0d busy=%b expected runs=%0d busy=0", run_cnt, busy, base); end
        imm_q.delete();
        base = run_cnt;
        launch(7'd5);
        write_word(AW'(0), 16'h01FF);
        wait_end();
        n_cmp++; if (finished !== 1'b1 || pc !== 7'd5) begin n_bad++; $display("FAIL restart_end: got fin=%b pc=%0d expected fin=1 pc=5", finished, pc); end
        n_cmp++; if (retired !== 16'd3) begin n_bad++; $display("FAIL restart_retired: got %0d expected 3", retired); end
        n_cmp++; if (r[0] !== 16'h0008) begin n_bad++; $display("FAIL restart_r0: got %h expected 0008", r[0]); end
        n_cmp++; if (run_cnt - base !== 3) begin n_bad++; $display("FAIL restart_runs: got %0d expected 3", run_cnt - base); end
        n_cmp++; if (imm_q[0] !== 16'h0005 || imm_q[1] !== 16'h0003) begin n_bad++; $display("FAIL restart_imm: got %h/%h expected 0005/0003", imm_q[0], imm_q[1]); end
        // mem[0] must still be mvi, so a one-word program stops as truncated.
        launch(7'd1);
        n_cmp++; if (bus.run !== 1'b0) begin n_bad++; $display("FAIL lockout_run: got %b expected 0", bus.run); end
        tick();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL lockout_error: got %b expected 1", error); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_zero_len();
        test_truncated();
        test_timeout();
        test_protocol();
        test_reset_mid_and_lockout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
